bp_top_linear_pipe: RTL and testbench
=====================================

Name: bp_top_linear_pipe

Overview:
- Parametrised, pipelined successor of the Boyar-Peralta masked S-box top linear layer.
- Processes NLANES bytes per transfer. Each byte is d-share Boolean masked.
- Mode input selects the forward S-box path or the inverse S-box path. The inverse path applies the inverse affine map first, then the same top-layer equations.
- Sits between the state/key datapath and the masked nonlinear core. Valid/ready handshake, PIPE register stages, every share registered separately (glitch barrier).

Parameters:
- d, 2, number of shares (>=2).
- NLANES, 4, S-box lanes processed in parallel (1..16).
- PIPE, 1, register stages between input and output (1 or 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input transfer valid.
- in_ready  output  1  block accepts input this cycle.
- in_mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled with the input data.
- in_data  input  NLANES*8*d  lane l, top bit i_j (j=0..7; i0 = byte bit 7, i7 = bit 0) at [((l*8+j)*d) +: d].
- out_valid  output  1  output transfer valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  NLANES*22*d  lane l, term k at [((l*22+k)*d) +: d]. Order k=0..21: t1,t2,t3,t4,t6,t8,t9,t10,t13,t14,t15,t16,t17,t19,t20,t22,t23,t24,t25,t26,t27,y5.

Behaviour:
- Linear map, computed share-wise: XOR is per share. XNOR = XOR with share 0 inverted; shares 1..d-1 are untouched.
- Forward equations:
  - t23=i7^i4; t22=~(i6^i4); t2=~(i7^i6); t1=i4^i3; t24=~(i3^i0); r5=i1^i0.
  - t8=~(i6^t23); t19=t22^r5; t9=~(i0^t1); t10=t2^t24; t13=t2^r5; t3=t1^r5; t25=~(i5^t1).
  - r13=i6^i1; t17=~(i5^t19); t20=t24^r13; t4=i3^t8.
  - r17=~(i5^i2); r18=~(i2^i1); r19=~(i5^i3).
  - y5=i7^r17; t6=t22^r17; t16=r13^r19; t27=t1^r18; t15=t10^t27; t14=t10^r18; t26=t3^t16.
- Inverse mode (in_mode=1):
  - Byte b is first replaced by rotl(b,1)^rotl(b,3)^rotl(b,6)^0x05. The rotations are applied per share; the constant is applied to share 0 only.
  - The result then feeds the forward equations.
- No randomness is consumed. Shares never mix.
- Pipeline:
  - PIPE stages, each holding a valid bit plus the data.
  - When PIPE=1, the single register sits after the linear map.
  - When PIPE=2, the first stage registers the post-affine byte shares and mode result; the second registers the 22 terms.
  - Stage s loads when its valid=0 or the next stage (or out_ready for the last stage) accepts.
  - in_ready = stage-1 load condition.
  - out_valid = last-stage valid.
  - out_data = last-stage register; never combinational from in_data.
- Latency: first output PIPE cycles after an accepted input. With out_ready held at 1, throughput is one transfer per cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_valid are held stable. in_ready falls once all stages are full. No transfer is dropped or duplicated.
- Simultaneous accept and output: a full stage whose content leaves this cycle may load new data in the same cycle.
- Reset:
  - Clears all valid bits and all data registers to 0: out_valid=0, out_data=0.
  - in_ready=0 during the rst cycle and 1 on the first cycle after.
  - Reset mid-operation discards in-flight data. No output appears for transfers accepted before reset.
- in_mode, in_data are don't-care when in_valid=0. Registers do not load on in_valid=0 except the valid bit.

Optional Feature:
- Macro BP_LIN_INV_EN.
- Defined: inverse-mode affine pre-stage present, in_mode honoured as above.
- Undefined: affine pre-stage not built; in_mode port kept but ignored, all transfers use the forward map; PIPE=2 first stage registers raw input shares.

Test Plan:
- Reset then unmasked byte 0x00 on all lanes (shares 1..d-1 = 0), mode 0, out_ready=1 -> after PIPE cycles out_valid=1. Per lane, share 0 recombined terms k21..k0 = 0x3EEF6A; other shares 0.
- Mode 1, byte 0x63 all lanes, with BP_LIN_INV_EN defined -> recombined terms = 0x3EEF6A per lane. Without the macro, output = forward map of 0x63.
- Random masking, d=3: byte 0x00 split into random shares -> XOR of shares per term = 0x3EEF6A. Repeat with 256 random bytes against the golden model; every term matches.
- Stream 10 transfers while toggling out_ready 1,0,0,1: out_data stable while stalled, in_ready=0 when all stages are full, outputs in order, count = 10.
- Assert rst for one cycle with 2 transfers in flight -> out_valid=0, out_data=0 next cycle. The first post-reset transfer emerges after exactly PIPE cycles.
- Back-to-back inputs, out_ready=1, alternating mode 0/1 -> one output per cycle, each with the mode it was accepted with.

Source files
------------

// File: rtl/bp_top_linear_pipe.sv
// bp_top_linear_pipe: pipelined, share-wise Boyar-Peralta top linear layer.
// Each lane maps one d-share masked byte to 22 masked terms. XOR is applied
// per share. XNOR inverts share 0 only, so shares never mix.
// Optional feature macro: BP_LIN_INV_EN adds the inverse-affine pre-stage
// selected by i_in_mode. Without the macro, i_in_mode is ignored.

`ifdef BP_LIN_INV_EN
// Inverse affine pre-map for one lane: rotl1^rotl3^rotl6 per share, 0x05 on share 0.
module bp_inv_aff_lane #(
    parameter int d = 2
) (
    input  logic           i_mode,
    input  logic [8*d-1:0] i_bits,
    output logic [8*d-1:0] o_bits
);
    logic [d-1:0][7:0] w_b;
    logic [d-1:0][7:0] w_a;

    for (genvar s = 0; s < d; s++) begin : g_sh
        localparam logic [7:0] CST = (s == 0) ? 8'h05 : 8'h00;
        // Gather share s into a byte. Top bit i_j is byte bit 7-j.
        for (genvar j = 0; j < 8; j++) begin : g_bit
            assign w_b[s][7-j]    = i_bits[j*d+s];
            assign o_bits[j*d+s]  = i_mode ? w_a[s][7-j] : w_b[s][7-j];
        end
        assign w_a[s] = {w_b[s][6:0], w_b[s][7]}
                      ^ {w_b[s][4:0], w_b[s][7:5]}
                      ^ {w_b[s][1:0], w_b[s][7:2]}
                      ^ CST;
    end
endmodule
`endif

// Top linear layer for one lane. All signals are d-share vectors.
module bp_lin_lane #(
    parameter int d = 2
) (
    input  logic [8*d-1:0]  i_bits,
    output logic [22*d-1:0] o_terms
);
    // XNOR on a masked value: flip share 0 only.
    localparam logic [d-1:0] NOT0 = {{(d-1){1'b0}}, 1'b1};

    logic [d-1:0] w_i0, w_i1, w_i2, w_i3, w_i4, w_i5, w_i6, w_i7;
    logic [d-1:0] w_t1, w_t2, w_t3, w_t4, w_t6, w_t8, w_t9, w_t10;
    logic [d-1:0] w_t13, w_t14, w_t15, w_t16, w_t17, w_t19, w_t20, w_t22;
    logic [d-1:0] w_t23, w_t24, w_t25, w_t26, w_t27, w_y5;
    logic [d-1:0] w_r5, w_r13, w_r17, w_r18, w_r19;

    assign w_i0 = i_bits[0*d +: d];
    assign w_i1 = i_bits[1*d +: d];
    assign w_i2 = i_bits[2*d +: d];
    assign w_i3 = i_bits[3*d +: d];
    assign w_i4 = i_bits[4*d +: d];
    assign w_i5 = i_bits[5*d +: d];
    assign w_i6 = i_bits[6*d +: d];
    assign w_i7 = i_bits[7*d +: d];

    // First level
    assign w_t23 = w_i7 ^ w_i4;
    assign w_t22 = w_i6 ^ w_i4 ^ NOT0;
    assign w_t2  = w_i7 ^ w_i6 ^ NOT0;
    assign w_t1  = w_i4 ^ w_i3;
    assign w_t24 = w_i3 ^ w_i0 ^ NOT0;
    assign w_r5  = w_i1 ^ w_i0;

    // Second level
    assign w_t8  = w_i6 ^ w_t23 ^ NOT0;
    assign w_t19 = w_t22 ^ w_r5;
    assign w_t9  = w_i0 ^ w_t1 ^ NOT0;
    assign w_t10 = w_t2 ^ w_t24;
    assign w_t13 = w_t2 ^ w_r5;
    assign w_t3  = w_t1 ^ w_r5;
    assign w_t25 = w_i5 ^ w_t1 ^ NOT0;

    // Third level
    assign w_r13 = w_i6 ^ w_i1;
    assign w_t17 = w_i5 ^ w_t19 ^ NOT0;
    assign w_t20 = w_t24 ^ w_r13;
    assign w_t4  = w_i3 ^ w_t8;

    assign w_r17 = w_i5 ^ w_i2 ^ NOT0;
    assign w_r18 = w_i2 ^ w_i1 ^ NOT0;
    assign w_r19 = w_i5 ^ w_i3 ^ NOT0;

    // Last level
    assign w_y5  = w_i7 ^ w_r17;
    assign w_t6  = w_t22 ^ w_r17;
    assign w_t16 = w_r13 ^ w_r19;
    assign w_t27 = w_t1 ^ w_r18;
    assign w_t15 = w_t10 ^ w_t27;
    assign w_t14 = w_t10 ^ w_r18;
    assign w_t26 = w_t3 ^ w_t16;

    // Term k=0 sits in the least significant d bits.
    assign o_terms = {w_y5, w_t27, w_t26, w_t25, w_t24, w_t23, w_t22, w_t20,
                      w_t19, w_t17, w_t16, w_t15, w_t14, w_t13, w_t10, w_t9,
                      w_t8, w_t6, w_t4, w_t3, w_t2, w_t1};
endmodule

// Pipelined wrapper: NLANES lanes, PIPE register stages, valid/ready chain.
module bp_top_linear_pipe #(
    parameter int d      = 2,
    parameter int NLANES = 4,
    parameter int PIPE   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_mode,
    input  logic [NLANES*8*d-1:0]  i_in_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [NLANES*22*d-1:0] o_out_data
);
    localparam int BW = NLANES*8*d;
    localparam int TW = NLANES*22*d;

    logic [BW-1:0] w_pre;
    logic [BW-1:0] w_lin_in;
    logic [TW-1:0] w_terms;
    logic [TW-1:0] r_terms;
    logic [PIPE:1] r_vld;
    logic [PIPE:1] w_ld;

`ifdef BP_LIN_INV_EN
    for (genvar l = 0; l < NLANES; l++) begin : g_aff
        bp_inv_aff_lane #(.d(d)) u_aff (
            .i_mode (i_in_mode),
            .i_bits (i_in_data[l*8*d +: 8*d]),
            .o_bits (w_pre[l*8*d +: 8*d])
        );
    end
`else
    // Mode is accepted on the port but has no effect in this build.
    logic w_unused_mode;
    assign w_unused_mode = i_in_mode;
    assign w_pre         = i_in_data;
`endif

    for (genvar l = 0; l < NLANES; l++) begin : g_lin
        bp_lin_lane #(.d(d)) u_lin (
            .i_bits  (w_lin_in[l*8*d +: 8*d]),
            .o_terms (w_terms[l*22*d +: 22*d])
        );
    end

    if (PIPE == 1) begin : g_p1
        assign w_lin_in = w_pre;
        assign w_ld[1]  = !r_vld[1] || i_out_ready;

        // Single stage: register the terms straight after the linear map.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_vld[1] <= 1'b0;
                r_terms  <= '0;
            end else if (w_ld[1]) begin
                r_vld[1] <= i_in_valid;
                if (i_in_valid) r_terms <= w_terms;
            end
        end
    end else begin : g_p2
        logic [BW-1:0] r_byte;

        assign w_lin_in = r_byte;
        assign w_ld[2]  = !r_vld[2] || i_out_ready;
        assign w_ld[1]  = !r_vld[1] || w_ld[2];

        // Two stages: byte shares (after the optional affine), then the terms.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_vld   <= '0;
                r_byte  <= '0;
                r_terms <= '0;
            end else begin
                if (w_ld[1]) begin
                    r_vld[1] <= i_in_valid;
                    if (i_in_valid) r_byte <= w_pre;
                end
                if (w_ld[2]) begin
                    r_vld[2] <= r_vld[1];
                    if (r_vld[1]) r_terms <= w_terms;
                end
            end
        end
    end

    assign o_in_ready  = w_ld[1] && !i_rst;
    assign o_out_valid = r_vld[PIPE];
    assign o_out_data  = r_terms;
endmodule

// File: tb/tb_bp_top_linear_pipe.sv
// Directed bench for bp_top_linear_pipe (d=3, 4 lanes, 2 stages) with a
// scoreboard that recombines shares and compares against a golden model.
module tb_bp_top_linear_pipe;
    localparam int D  = 3;
    localparam int NL = 4;
    localparam int PP = 2;
    localparam int BW = NL*8*D;
    localparam int TW = NL*22*D;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          in_mode   = 1'b0;
    logic [BW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [TW-1:0] out_data;

    int n_chk = 0;
    int n_fail = 0;
    int n_out = 0;
    logic saw_full = 1'b0;
    logic prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic [NL*22-1:0] sb_q[$];
    logic [NL*22-1:0] mon_e;
    logic [NL*22-1:0] mon_x;
    logic [7:0] mon_b;
    logic [7:0] lb[NL];

    always #5 clk = ~clk;

    bp_top_linear_pipe #(.d(D), .NLANES(NL), .PIPE(PP)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_mode   (in_mode),
        .i_in_data   (in_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Golden forward map on an unmasked byte; i0 is byte bit 7.
    function automatic logic [21:0] fwd(input logic [7:0] b);
        logic i0, i1, i2, i3, i4, i5, i6, i7;
        logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15, t16, t17, t19, t20;
        logic t22, t23, t24, t25, t26, t27, y5, r5, r13, r17, r18, r19;
        {i0, i1, i2, i3, i4, i5, i6, i7} = b;
        t23 = i7 ^ i4;   t22 = ~(i6 ^ i4); t2 = ~(i7 ^ i6);
        t1 = i4 ^ i3;    t24 = ~(i3 ^ i0); r5 = i1 ^ i0;
        t8 = ~(i6 ^ t23); t19 = t22 ^ r5;  t9 = ~(i0 ^ t1);
        t10 = t2 ^ t24;  t13 = t2 ^ r5;    t3 = t1 ^ r5;   t25 = ~(i5 ^ t1);
        r13 = i6 ^ i1;   t17 = ~(i5 ^ t19); t20 = t24 ^ r13; t4 = i3 ^ t8;
        r17 = ~(i5 ^ i2); r18 = ~(i2 ^ i1); r19 = ~(i5 ^ i3);
        y5 = i7 ^ r17;   t6 = t22 ^ r17;   t16 = r13 ^ r19; t27 = t1 ^ r18;
        t15 = t10 ^ t27; t14 = t10 ^ r18;  t26 = t3 ^ t16;
        return {y5, t27, t26, t25, t24, t23, t22, t20, t19, t17, t16, t15, t14,
                t13, t10, t9, t8, t6, t4, t3, t2, t1};
    endfunction

`ifdef BP_LIN_INV_EN
    function automatic logic [7:0] aff(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction
`endif

    function automatic logic [7:0] in_byte(input logic [BW-1:0] v, input int l);
        logic [7:0] b = '0;
        for (int j = 0; j < 8; j++)
            for (int s = 0; s < D; s++) b[7-j] ^= v[(l*8+j)*D+s];
        return b;
    endfunction

    function automatic logic [21:0] out_term(input logic [TW-1:0] v, input int l);
        logic [21:0] t = '0;
        for (int k = 0; k < 22; k++)
            for (int s = 0; s < D; s++) t[k] ^= v[(l*22+k)*D+s];
        return t;
    endfunction

    function automatic logic hi_shares_zero(input logic [TW-1:0] v);
        logic z = 1'b1;
        for (int i = 0; i < NL*22; i++)
            for (int s = 1; s < D; s++) if (v[i*D+s]) z = 1'b0;
        return z;
    endfunction

    // Scoreboard: in_ready model, stall stability, in-order output checks.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, (sb_q.size() < PP) || out_ready);
            if (in_valid && !in_ready) saw_full = 1'b1;
            if (prev_stall) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_data", out_data == prev_data, 1);
            end
            if (out_valid && out_ready) begin
                n_out++;
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    for (int l = 0; l < NL; l++) mon_x[l*22 +: 22] = out_term(out_data, l);
                    for (int l = 0; l < NL; l++) chk("sb_term", mon_x[l*22 +: 22], mon_e[l*22 +: 22]);
                end
            end
            if (in_valid && in_ready) begin
                for (int l = 0; l < NL; l++) begin
                    mon_b = in_byte(in_data, l);
`ifdef BP_LIN_INV_EN
                    if (in_mode) mon_b = aff(mon_b);
`endif
                    mon_e[l*22 +: 22] = fwd(mon_b);
                end
                sb_q.push_back(mon_e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Present lb[] as a transfer (random masks when masked=1), wait for accept.
    task automatic drive(input logic mode, input bit masked);
        logic [7:0] acc;
        logic [7:0] m;
        int w;
        for (int l = 0; l < NL; l++) begin
            acc = lb[l];
            for (int s = 1; s < D; s++) begin
                m = masked ? 8'($urandom_range(0, 255)) : 8'h00;
                acc ^= m;
                for (int j = 0; j < 8; j++) in_data[(l*8+j)*D+s] = m[7-j];
            end
            for (int j = 0; j < 8; j++) in_data[(l*8+j)*D] = acc[7-j];
        end
        in_mode  = mode;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("send_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < BW; i++) in_data[i] = 1'($urandom);
        in_mode = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int lat;
        int base;
        logic [21:0] exp_b;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ovld", out_valid, 0);
        chk("rst_odata_zero", out_data == '0, 1);
        chk("rst_iready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_iready", in_ready, 1);
        @(posedge clk);
        #1;

        // Unmasked 0x00, forward
        for (int l = 0; l < NL; l++) lb[l] = 8'h00;
        drive(1'b0, 1'b0);
        wait_out(lat);
        chk("a_latency", lat, PP);
        for (int l = 0; l < NL; l++) chk("a_term", out_term(out_data, l), 22'h3EEF6A);
        chk("a_hi_shares_zero", hi_shares_zero(out_data), 1);

        // 0x63 in inverse mode
`ifdef BP_LIN_INV_EN
        exp_b = 22'h3EEF6A;
`else
        exp_b = 22'h376E6E;
`endif
        for (int l = 0; l < NL; l++) lb[l] = 8'h63;
        drive(1'b1, 1'b0);
        wait_out(lat);
        for (int l = 0; l < NL; l++) chk("b_term", out_term(out_data, l), exp_b);

        // Masked 0x00 with random shares
        for (int l = 0; l < NL; l++) lb[l] = 8'h00;
        drive(1'b0, 1'b1);
        wait_out(lat);
        for (int l = 0; l < NL; l++) chk("c_term", out_term(out_data, l), 22'h3EEF6A);

        // All 256 byte values, masked, random mode, back-to-back
        for (int t = 0; t < 64; t++) begin
            for (int l = 0; l < NL; l++) lb[l] = 8'(t*NL + l);
            drive(1'($urandom), 1'b1);
        end
        repeat (5) @(posedge clk);
        #1;

        // Stream 10 transfers under out_ready pattern 1,0,0,1
        base = n_out;
        saw_full = 1'b0;
        fork
            begin
                for (int t = 0; t < 10; t++) begin
                    for (int l = 0; l < NL; l++) lb[l] = 8'($urandom_range(0, 255));
                    drive(1'($urandom), 1'b1);
                end
            end
            begin
                int c = 0;
                while (n_out < base + 10 && c < 200) begin
                    out_ready = pat[c % 4];
                    @(posedge clk);
                    #1;
                    c++;
                end
                out_ready = 1'b1;
            end
        join
        chk("d_count", n_out - base, 10);
        chk("d_saw_full", saw_full, 1);

        // Reset with two transfers in flight
        out_ready = 1'b0;
        lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33; lb[3] = 8'h44;
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("e_rst_iready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("e_ovld", out_valid, 0);
        chk("e_odata_zero", out_data == '0, 1);
        chk("e_iready", in_ready, 1);
        @(posedge clk);
        #1;
        base = n_out;
        lb[0] = 8'hA5; lb[1] = 8'h5A; lb[2] = 8'hFF; lb[3] = 8'h01;
        drive(1'b0, 1'b1);
        wait_out(lat);
        chk("e_latency", lat, PP);
        @(posedge clk);
        #1;
        chk("e_count", n_out - base, 1);

        // Back-to-back, alternating mode, one output per cycle
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    for (int l = 0; l < NL; l++) lb[l] = 8'($urandom_range(0, 255));
                    drive(1'(t), 1'b1);
                end
            end
            begin
                int w = 0;
                @(negedge clk);
                while (!out_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 8; i++) begin
                    chk("f_streak", out_valid, 1);
                    if (i < 7) @(negedge clk);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
